// File: rtl/serial_add_sub_if.sv
// Handshake and data bundle for the bit-serial adder/subtractor.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    // Requester side: issues operations, observes status and results
    modport master (
        output start, op, a, b,
        input  busy, done, result, cout, overflow
    );

    // Engine side
    modport slave (
        input  start, op, a, b,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-add/full-sub slice, LSB first,
// one bit per clock. Result and flags are held until the next operation
// completes.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_sub_if.slave    bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, sr;
    logic [WIDTH-1:0] result_q;
    logic             c, op_q, cout_q, ovf_q;
    logic [CW-1:0]    cnt;

    logic             s, c_nxt, accept, last;

    // Operations are only accepted when the engine is not running
    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    // Single bit slice: sum/difference bit and next carry/borrow
    always_comb begin
        s = sa[0] ^ sb[0] ^ c;
        if (op_q)
            c_nxt = (~sa[0] & sb[0]) | (c & ~(sa[0] ^ sb[0]));
        else
            c_nxt = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.start ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state so reset clears them immediately
    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    // Datapath: load operands, shift one bit per cycle, publish on last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            sr       <= '0;
            c        <= 1'b0;
            op_q     <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            sa   <= bus.a;
            sb   <= bus.b;
            op_q <= bus.op;
            c    <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= {s, sr[WIDTH-1:1]};
            c   <= c_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
                // c is the carry into the MSB slice; XOR with carry out
                // gives two's-complement overflow for both add and sub
                result_q <= {s, sr[WIDTH-1:1]};
                cout_q   <= c_nxt;
                ovf_q    <= c ^ c_nxt;
            end
        end
    end

    // Published results
    always_comb begin
        bus.result   = result_q;
        bus.cout     = cout_q;
        bus.overflow = ovf_q;
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub (WIDTH=8): table of add/sub vectors
// plus hand-written sequences for busy isolation, back-to-back and reset.
module tb_serial_add_sub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [7:0] prev_res = 8'h00;

    serial_add_sub_if #(.WIDTH(8)) bus();

    serial_add_sub #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       cout;
        logic       ovf;
        string      name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one operation and follow it to its done pulse
    task automatic do_op(input logic o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] er, input logic ec, input logic eo,
                         input string nm);
        int n;
        int bcnt;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 1'($urandom);
        n = 0; bcnt = 0;
        while (!bus.done && n < 20) begin
            if (bus.busy) bcnt++;
            if (n == 0 || n == 7) check({nm, " held"}, 32'(bus.result), 32'(prev_res));
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, n, 8);
        check({nm, " busy cycles"}, bcnt, 8);
        check({nm, " busy in done"}, 32'(bus.busy), 0);
        check({nm, " result"}, 32'(bus.result), 32'(er));
        check({nm, " cout"}, 32'(bus.cout), 32'(ec));
        check({nm, " overflow"}, 32'(bus.overflow), 32'(eo));
        prev_res = er;
    endtask

    initial begin
        int n;
        int ndone;
        vecs[0] = '{1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, "add 35+4a"};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "add ff+01"};
        vecs[2] = '{1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "sub 05-03"};
        vecs[3] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "sub 03-05"};
        vecs[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, "add 7f+01"};
        vecs[5] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "sub 80-01"};
        vecs[6] = '{1'b1, 8'h00, 8'h80, 8'h80, 1'b1, 1'b1, "sub 00-80"};

        bus.start = 1'b0; bus.op = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
        #12;
        check("reset busy", 32'(bus.busy), 0);
        check("reset done", 32'(bus.done), 0);
        check("reset result", 32'(bus.result), 0);
        check("reset cout", 32'(bus.cout), 0);
        check("reset overflow", 32'(bus.overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                  vecs[i].cout, vecs[i].ovf, vecs[i].name);

        // Busy isolation: start held and operands changed during RUN
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 8'h10; bus.b = 8'h20;
        @(negedge clk);
        bus.a = 8'hFF; bus.op = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 6) bus.start = 1'b0;
            if (i == 3) check("iso held", 32'(bus.result), 32'(prev_res));
            if (bus.done) begin
                ndone++;
                check("iso result", 32'(bus.result), 32'h30);
            end
            @(negedge clk);
        end
        check("iso done count", ndone, 1);
        prev_res = 8'h30;

        // Back-to-back: new sub accepted in the DONE cycle of an add
        do_op(1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, "add 01+02");
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 8'h0A; bus.b = 8'h0F;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        check("b2b busy", 32'(bus.busy), 1);
        check("b2b done low", 32'(bus.done), 0);
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b spacing", n, 9);
        check("b2b result", 32'(bus.result), 32'hFB);
        check("b2b cout", 32'(bus.cout), 1);
        check("b2b overflow", 32'(bus.overflow), 0);

        // Asynchronous reset three cycles into RUN
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 8'h7F; bus.b = 8'h7F;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst busy", 32'(bus.busy), 0);
        check("rst done", 32'(bus.done), 0);
        check("rst result", 32'(bus.result), 0);
        check("rst cout", 32'(bus.cout), 0);
        check("rst overflow", 32'(bus.overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_res = 8'h00;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("no done after abort", ndone, 0);
        do_op(1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, "add 01+01");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
